// File: rtl/ps2_keyboard_pkg.sv
// Shared register map, prefix bytes and event format for the PS/2 keyboard block.
// Serves as the kb_regs companion to the system memory-size definitions.
package ps2_keyboard_pkg;

    localparam int unsigned KB_ADDR_WIDTH  = 4;
    localparam int unsigned KB_EVENT_WIDTH = 10;

    localparam logic [KB_ADDR_WIDTH-1:0] KB_REG_STATUS = 4'd0;
    localparam logic [KB_ADDR_WIDTH-1:0] KB_REG_DATA   = 4'd1;
    localparam logic [KB_ADDR_WIDTH-1:0] KB_REG_LAST   = 4'd2;

    localparam int unsigned KB_ST_NEMPTY    = 0;
    localparam int unsigned KB_ST_OVF       = 1;
    localparam int unsigned KB_ST_PERR      = 2;
    localparam int unsigned KB_ST_FERR      = 3;
    localparam int unsigned KB_ST_COUNT_LSB = 8;
    localparam int unsigned KB_VALID_BIT    = 16;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef logic [KB_EVENT_WIDTH-1:0] kb_event_t;

    function automatic logic odd_parity_ok(logic [7:0] data, logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit deserialiser
// with idle timeout, and a combinational parity/framing check on the final bit.
module ps2_rx
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       perr_pulse,
    output logic       ferr_pulse
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    logic          fall_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    frame_q;
    logic [TW-1:0] to_cnt_q;

    logic last_bit, frame_bad, par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            fall_q      <= clk_prev_q & ~clk_sync_q[1];
        end
    end

    // frame_q shifts right: after ten bits, [0] is start, [8:1] data, [9] parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 4'd0;
            frame_q   <= 10'd0;
            to_cnt_q  <= '0;
        end else if (fall_q) begin
            to_cnt_q <= '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_q <= 4'd0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                frame_q   <= {data_sync_q[1], frame_q[9:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_q <= 4'd0;
                to_cnt_q  <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rx_byte    = frame_q[8:1];
        last_bit   = fall_q && (bit_cnt_q == 4'd10);
        frame_bad  = frame_q[0] | ~data_sync_q[1];
        par_bad    = ~odd_parity_ok(frame_q[8:1], frame_q[9]);
        byte_valid = last_bit & ~frame_bad & ~par_bad;
        perr_pulse = last_bit & par_bad;
        ferr_pulse = last_bit & frame_bad;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard register block: folds E0/F0 prefixes into 10-bit key events,
// buffers them in a FIFO and serves STATUS/DATA/LAST reads with pop and sticky clear.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     kb_read,
    input  logic [KB_ADDR_WIDTH-1:0] kb_addr,
    output logic [31:0]              kb_rdata
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic       byte_valid, perr_pulse, ferr_pulse;
    logic [7:0] rx_byte;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .perr_pulse(perr_pulse),
        .ferr_pulse(ferr_pulse)
    );

    kb_event_t         mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              ext_q, brk_q;
    logic              ovf_q, perr_q, ferr_q;
    kb_event_t         last_q;
    logic              last_valid_q;

    logic      is_prefix, push_req, push, pop, ovf_set, full, empty, rd_status, rd_data;
    kb_event_t new_event;

    always_comb begin
        is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
        push_req  = byte_valid & ~is_prefix;
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        rd_status = kb_read && (kb_addr == KB_REG_STATUS);
        rd_data   = kb_read && (kb_addr == KB_REG_DATA);
        pop       = rd_data & ~empty;
        // A pop on the same edge frees the slot the incoming event needs.
        push      = push_req & (~full | pop);
        ovf_set   = push_req & full & ~pop;
        new_event = {brk_q, ext_q, rx_byte};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= new_event;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            ovf_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                last_q       <= new_event;
                last_valid_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);

            if (perr_pulse || ferr_pulse) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end

            ovf_q  <= ovf_set    | (ovf_q  & ~rd_status);
            perr_q <= perr_pulse | (perr_q & ~rd_status);
            ferr_q <= ferr_pulse | (ferr_q & ~rd_status);
        end
    end

    always_comb begin
        kb_rdata = '0;
        case (kb_addr)
            KB_REG_STATUS: begin
                kb_rdata[KB_ST_NEMPTY] = ~empty;
                kb_rdata[KB_ST_OVF]    = ovf_q;
                kb_rdata[KB_ST_PERR]   = perr_q;
                kb_rdata[KB_ST_FERR]   = ferr_q;
                kb_rdata[KB_ST_COUNT_LSB +: 8] = 8'(count_q);
            end
            KB_REG_DATA: begin
                if (!empty) begin
                    kb_rdata[KB_EVENT_WIDTH-1:0] = mem[rd_ptr_q];
                    kb_rdata[KB_VALID_BIT]       = 1'b1;
                end
            end
            KB_REG_LAST: begin
                kb_rdata[KB_EVENT_WIDTH-1:0] = last_q;
                kb_rdata[KB_VALID_BIT]       = last_valid_q;
            end
            default: kb_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: fixed vector table, hand-written corner
// sequences, and random frames checked against a queue-based reference model.
module tb_ps2_keyboard;
    import ps2_keyboard_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 300;
    localparam int HALF  = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ps2_clk = 1'b1;
    logic                     ps2_data = 1'b1;
    logic                     kb_read = 1'b0;
    logic [KB_ADDR_WIDTH-1:0] kb_addr = '0;
    logic [31:0]              kb_rdata;

    always #5 clk = ~clk;

    ps2_keyboard #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .kb_read (kb_read),
        .kb_addr (kb_addr),
        .kb_rdata(kb_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: event queue plus architectural flags.
    logic [9:0] m_q[$];
    bit         m_ovf, m_perr, m_ferr, m_ext, m_brk, m_last_v;
    logic [9:0] m_last;

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 0; m_perr = 0; m_ferr = 0; m_ext = 0; m_brk = 0;
        m_last_v = 0; m_last = '0;
    endfunction

    function automatic logic [31:0] model_rdata(int idx);
        logic [31:0] r;
        r = 32'd0;
        if (idx == 0) begin
            r = (m_q.size() != 0 ? 32'd1 : 32'd0) + (m_ovf ? 32'd2 : 32'd0)
              + (m_perr ? 32'd4 : 32'd0) + (m_ferr ? 32'd8 : 32'd0)
              + 32'(m_q.size()) * 256;
        end else if (idx == 1) begin
            if (m_q.size() != 0) r = 32'h10000 + 32'(m_q[0]);
        end else if (idx == 2) begin
            if (m_last_v) r = 32'h10000 + 32'(m_last);
        end
        return r;
    endfunction

    function automatic void model_frame(logic [7:0] b, bit bad_par, bit bad_stop, bit pop);
        logic [9:0] ev;
        if (bad_par || bad_stop) begin
            if (bad_par) m_perr = 1;
            if (bad_stop) m_ferr = 1;
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            ev = {m_brk, m_ext, b};
            if (pop && m_q.size() != 0) void'(m_q.pop_front());
            if (m_q.size() < DEPTH) begin
                m_q.push_back(ev);
                m_last = ev;
                m_last_v = 1;
            end else begin
                m_ovf = 1;
            end
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(logic b);
        ps2_data = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    // pop_at_push raises a DATA read during the cycle whose edge performs the push.
    task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop, bit pop_at_push);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_data = ~bad_stop;
        idle(HALF);
        ps2_clk = 1'b0;
        if (pop_at_push) begin
            idle(3);
            kb_addr = KB_REG_DATA;
            kb_read = 1'b1;
            idle(1);
            kb_read = 1'b0;
            idle(HALF - 4);
        end else begin
            idle(HALF);
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(HALF);
        model_frame(b, bad_par, bad_stop, pop_at_push);
    endtask

    task automatic rd(int idx, output logic [31:0] got);
        kb_addr = KB_ADDR_WIDTH'(idx);
        kb_read = 1'b1;
        #1 got = kb_rdata;
        @(negedge clk);
        kb_read = 1'b0;
        if (idx == 1 && m_q.size() != 0) void'(m_q.pop_front());
        if (idx == 0) begin
            m_ovf = 0; m_perr = 0; m_ferr = 0;
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reg(string name, int idx, logic [31:0] exp);
        logic [31:0] got;
        rd(idx, got);
        check(name, got, exp);
    endtask

    task automatic chk_model(string name, int idx);
        logic [31:0] exp;
        exp = model_rdata(idx);
        chk_reg(name, idx, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(3);
        rst_n = 1'b1;
        model_reset();
        idle(2);
    endtask

    typedef struct {
        bit          send;
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(1);
        #1 check("in_reset_status", kb_rdata, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) chk_reg($sformatf("reset_idx%0d", i), i, 32'd0);

        // send, byte, bad parity, bad stop, read index, expected word
        tbl.push_back('{1, 8'h1C, 0, 0, 0, 32'h0000_0101});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h0001_001C});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0000_0000});
        tbl.push_back('{1, 8'hE0, 0, 0, 0, 32'h0000_0000});
        tbl.push_back('{1, 8'hF0, 0, 0, 0, 32'h0000_0000});
        tbl.push_back('{1, 8'h75, 0, 0, 0, 32'h0000_0101});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h0001_0375});
        tbl.push_back('{0, 8'h00, 0, 0, 2, 32'h0001_0375});
        tbl.push_back('{1, 8'h1C, 1, 0, 0, 32'h0000_0004});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0000_0000});
        tbl.push_back('{1, 8'h5A, 0, 1, 0, 32'h0000_0008});
        tbl.push_back('{0, 8'h00, 0, 0, 3, 32'h0000_0000});
        tbl.push_back('{0, 8'h00, 0, 0, 15, 32'h0000_0000});
        tbl.push_back('{0, 8'h00, 0, 0, 2, 32'h0001_0375});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h0000_0000});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].send) send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, 0);
            idle(2);
            chk_reg($sformatf("vec%0d", i), tbl[i].idx, tbl[i].exp);
        end

        // Overflow: 17 events into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
        chk_reg("ovf_status", 0, 32'h0000_1003);
        chk_reg("ovf_last", 2, 32'h0001_001F);
        for (int i = 0; i < 16; i++)
            chk_reg($sformatf("ovf_pop%0d", i), 1, 32'h0001_0010 + 32'(i));
        chk_reg("ovf_drained", 0, 32'd0);

        // Full FIFO with a DATA pop on the same edge as the push.
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 0, 0, 0);
        send_frame(8'h60, 0, 0, 1);
        chk_reg("full_pop_status", 0, 32'h0000_1001);
        for (int i = 0; i < 16; i++) chk_model($sformatf("full_pop_drain%0d", i), 1);
        chk_reg("full_pop_empty", 0, 32'd0);

        // Abandoned partial frame recovered by timeout.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        idle(TMO + 10);
        send_frame(8'h29, 0, 0, 0);
        chk_reg("timeout_data", 1, 32'h0001_0029);
        chk_reg("timeout_status", 0, 32'd0);

        // Random frames against the model.
        for (int n = 0; n < 60; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 12) b = 8'hE0;
            else if (r < 22) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, 0);
            if ($urandom_range(0, 2) != 0) chk_model($sformatf("rand%0d", n), $urandom_range(0, 4));
        end
        chk_model("rand_status", 0);
        chk_model("rand_last", 2);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (m_q.size() != 0) chk_model($sformatf("rand_drain%0d", i), 1);
        end

        // Reset in the middle of a frame with a non-empty FIFO.
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) chk_reg($sformatf("midreset_idx%0d", i), i, 32'd0);
        send_frame(8'h1C, 0, 0, 0);
        chk_reg("post_reset_data", 1, 32'h0001_001C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
